// File: rtl/sa_skew_feeder.sv
// Skewed A/B edge feeder for the systolic MAC array: buffers one N x N tile, then streams it diagonally.
// Define SKEW_FEEDER_PINGPONG_EN for a second tile bank so the next tile loads while the current one streams.
module sa_skew_feeder #(
   parameter int DATAWIDTH = 16,
   parameter int N = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [N*DATAWIDTH-1:0] in_a,
   input  logic [N*DATAWIDTH-1:0] in_b,
   output logic [N*DATAWIDTH-1:0] a_edge,
   output logic [N*DATAWIDTH-1:0] b_edge,
   output logic                   acc_clr,
   output logic                   busy,
   output logic                   done
);
   localparam int CW = $clog2(3*N);
   localparam int IW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST  = CW'(N-1);
   localparam logic [CW-1:0] CNT_FULL  = CW'(N);
   localparam logic [CW-1:0] STEP_LAST = CW'(3*N-2);

   typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

   state_t                 state_q, state_n;
   logic [CW-1:0]          step_q, step_n;
   logic [CW-1:0]          cnt_q, cnt_n;
   logic                   accept, full_n, swap, ready_n;
   logic [N*DATAWIDTH-1:0] a_nxt, b_nxt;
   logic [DATAWIDTH-1:0]   a_cur [N][N];
   logic [DATAWIDTH-1:0]   b_cur [N][N];

   assign accept = in_valid && in_ready;
   assign full_n = accept ? (cnt_q == CNT_LAST) : (cnt_q == CNT_FULL);

`ifdef SKEW_FEEDER_PINGPONG_EN
   logic                 fill_bank, rd_bank;
   logic [DATAWIDTH-1:0] a_buf [2][N][N];
   logic [DATAWIDTH-1:0] b_buf [2][N][N];

   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            a_buf[fill_bank][cnt_q[IW-1:0]][i] <= in_a[i*DATAWIDTH +: DATAWIDTH];
            b_buf[fill_bank][cnt_q[IW-1:0]][i] <= in_b[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   // The completed fill bank becomes the stream bank; filling moves to the other one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill_bank <= 1'b0;
         rd_bank   <= 1'b0;
      end else if (swap) begin
         rd_bank   <= fill_bank;
         fill_bank <= ~fill_bank;
      end
   end

   always_comb begin
      a_cur = a_buf[rd_bank];
      b_cur = b_buf[rd_bank];
   end

   assign ready_n = (cnt_n != CNT_FULL);
`else
   always_ff @(posedge clk) begin
      if (accept) begin
         for (int i = 0; i < N; i++) begin
            a_cur[cnt_q[IW-1:0]][i] <= in_a[i*DATAWIDTH +: DATAWIDTH];
            b_cur[cnt_q[IW-1:0]][i] <= in_b[i*DATAWIDTH +: DATAWIDTH];
         end
      end
   end

   assign ready_n = (state_n == LOAD);
`endif

   // Step 0 of STREAM is the acc_clr cycle; steps 1..3N-2 carry edge cycles 0..3N-3.
   always_comb begin
      state_n = state_q;
      step_n  = step_q;
      cnt_n   = cnt_q;
      swap    = 1'b0;
      if (accept) cnt_n = cnt_q + CW'(1);
      case (state_q)
         LOAD: begin
            if (full_n) begin
               state_n = STREAM;
               swap    = 1'b1;
            end
         end
         STREAM: begin
            if (step_q == STEP_LAST) begin
               state_n = DONE;
               step_n  = '0;
            end else begin
               step_n = step_q + CW'(1);
            end
         end
         DONE: begin
            if (full_n) begin
               state_n = STREAM;
               swap    = 1'b1;
            end else begin
               state_n = LOAD;
            end
         end
         default: state_n = LOAD;
      endcase
      if (swap) begin
         cnt_n  = '0;
         step_n = '0;
      end
   end

   // Beat k holds column k of A and row k of B, so one diagonal select serves both edges.
   always_comb begin
      a_nxt = '0;
      b_nxt = '0;
      if (state_n == STREAM && step_n != '0) begin
         for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
               if (int'(step_n) - 1 == i + k) begin
                  a_nxt[i*DATAWIDTH +: DATAWIDTH] = a_cur[k][i];
                  b_nxt[i*DATAWIDTH +: DATAWIDTH] = b_cur[k][i];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= LOAD;
         step_q   <= '0;
         cnt_q    <= '0;
         in_ready <= 1'b0;
         acc_clr  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         a_edge   <= '0;
         b_edge   <= '0;
      end else begin
         state_q  <= state_n;
         step_q   <= step_n;
         cnt_q    <= cnt_n;
         in_ready <= ready_n;
         acc_clr  <= swap;
         busy     <= (state_n != LOAD);
         done     <= (state_n == DONE);
         a_edge   <= a_nxt;
         b_edge   <= b_nxt;
      end
   end
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Scoreboard bench for sa_skew_feeder: tiles are queued on load, then edges, timing and a PE-array
// model's C = A*B are checked when the DUT streams them.
module tb_sa_skew_feeder;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int W  = N*DW;
   localparam int NSTEP = 3*N-2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a, in_b;
   logic [W-1:0] a_edge, b_edge;
   logic         acc_clr, busy, done;

   sa_skew_feeder #(.DATAWIDTH(DW), .N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .a_edge(a_edge), .b_edge(b_edge),
      .acc_clr(acc_clr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [N*N*DW-1:0] a;
      logic [N*N*DW-1:0] b;
      int                last_cyc;
   } tile_t;

   tile_t exp_q[$];
   int    tests = 0;
   int    fails = 0;
   int    gap_tab[N];

   function automatic logic [DW-1:0] el(input logic [N*N*DW-1:0] m, input int r, input int c);
      return m[(r*N+c)*DW +: DW];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops a tile at each acc_clr, checks every edge cycle and done, and runs a PE array model.
   bit           mon_stream = 1'b0;
   bit           mon_wait_done = 1'b0;
   int           mon_t, clr_cyc, exp_clr;
   int           prev_done = -1000;
   tile_t        cur;
   logic [W-1:0] ea, eb;
   logic [31:0]  pacc [N][N];
   logic [31:0]  csum;
   logic [DW-1:0] pa [N][N];
   logic [DW-1:0] pb [N][N];

   always @(negedge clk) begin
      if (!rst_n) begin
         mon_stream    = 1'b0;
         mon_wait_done = 1'b0;
         prev_done     = -1000;
         exp_q.delete();
      end else if (acc_clr) begin
         if (exp_q.size() == 0) begin
            checkOutput("acc_clr_unexpected", 64'(acc_clr), 64'd0);
         end else begin
            cur = exp_q.pop_front();
            exp_clr = (cur.last_cyc + 1 > prev_done + 1) ? cur.last_cyc + 1 : prev_done + 1;
            checkOutput("acc_clr_cycle", 64'(cyc), 64'(exp_clr));
            checkOutput("clr_edges_zero", 64'(a_edge | b_edge), 64'd0);
            clr_cyc = cyc;
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  pacc[i][j] = '0;
                  pa[i][j]   = '0;
                  pb[i][j]   = '0;
               end
            mon_t      = 0;
            mon_stream = 1'b1;
         end
      end else if (mon_stream) begin
         ea = '0;
         eb = '0;
         for (int i = 0; i < N; i++) begin
            if (mon_t - i >= 0 && mon_t - i < N) begin
               ea[i*DW +: DW] = el(cur.a, i, mon_t - i);
               eb[i*DW +: DW] = el(cur.b, mon_t - i, i);
            end
         end
         checkOutput($sformatf("a_edge_t%0d", mon_t), 64'(a_edge), 64'(ea));
         checkOutput($sformatf("b_edge_t%0d", mon_t), 64'(b_edge), 64'(eb));
         checkOutput("stream_flags", 64'({busy, done}), 64'd2);
         for (int i = 0; i < N; i++)
            for (int j = N-1; j > 0; j--) pa[i][j] = pa[i][j-1];
         for (int j = 0; j < N; j++)
            for (int i = N-1; i > 0; i--) pb[i][j] = pb[i-1][j];
         for (int i = 0; i < N; i++) begin
            pa[i][0] = a_edge[i*DW +: DW];
            pb[0][i] = b_edge[i*DW +: DW];
         end
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
               pacc[i][j] = pacc[i][j] + 32'(pa[i][j]) * 32'(pb[i][j]);
         mon_t++;
         if (mon_t == NSTEP) begin
            mon_stream    = 1'b0;
            mon_wait_done = 1'b1;
         end
      end else if (mon_wait_done) begin
         checkOutput("done_flags", 64'({busy, done}), 64'd3);
         checkOutput("done_cycle", 64'(cyc), 64'(clr_cyc + 3*N - 1));
         checkOutput("done_edges_zero", 64'(a_edge | b_edge), 64'd0);
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               csum = '0;
               for (int k = 0; k < N; k++)
                  csum = csum + 32'(el(cur.a, i, k)) * 32'(el(cur.b, k, j));
               checkOutput($sformatf("c_result[%0d][%0d]", i, j), 64'(pacc[i][j]), 64'(csum));
            end
         prev_done     = cyc;
         mon_wait_done = 1'b0;
      end else begin
         checkOutput("idle_a_edge", 64'(a_edge), 64'd0);
         checkOutput("idle_b_edge", 64'(b_edge), 64'd0);
         checkOutput("idle_flags", 64'({busy, done}), 64'd0);
      end
   end

   // Drives the N beats of a tile with gap_tab[k] idle cycles before beat k; queues it on the last accept.
   task automatic applyStimulus(input tile_t t);
      tile_t rec;
      bit    acc;
      int    guard;
      rec = t;
      for (int k = 0; k < N; k++) begin
         in_valid = 1'b0;
         repeat (gap_tab[k]) begin
            @(posedge clk);
            #1;
         end
         for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = el(t.a, i, k);
            in_b[i*DW +: DW] = el(t.b, k, i);
         end
         in_valid = 1'b1;
         acc   = 1'b0;
         guard = 0;
         while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc && k == N-1) begin
               rec.last_cyc = cyc;
               exp_q.push_back(rec);
            end
            @(posedge clk);
            #1;
            guard++;
         end
         if (!acc) checkOutput("beat_accept_timeout", 64'(acc), 64'd1);
      end
      in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int w = 0;
      while ((exp_q.size() != 0 || mon_stream || mon_wait_done) && w < 500) begin
         @(negedge clk);
         w++;
      end
      checkOutput("drain_timeout", 64'(exp_q.size() != 0 || mon_stream || mon_wait_done), 64'd0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   tile_t tt;

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      gap_tab  = '{0, 0, 0, 0};
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] idle after reset");
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         checkOutput("idle_in_ready", 64'(in_ready), 64'd1);
         checkOutput("idle_ctrl", 64'({busy, acc_clr, done}), 64'd0);
      end
      @(posedge clk);
      #1;

      $display("[TB] index-pattern tile, continuous valid");
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            tt.a[(i*N+k)*DW +: DW] = DW'(16*i + k);
            tt.b[(i*N+k)*DW +: DW] = DW'(256 + 4*i + k);
         end
      applyStimulus(tt);
      waitIdle();

      $display("[TB] backpressure valid pattern 1,0,0,1,0,1,1");
      for (int e = 0; e < N*N; e++) begin
         tt.a[e*DW +: DW] = DW'($urandom);
         tt.b[e*DW +: DW] = DW'($urandom);
      end
      gap_tab = '{0, 2, 1, 0};
      applyStimulus(tt);
`ifndef SKEW_FEEDER_PINGPONG_EN
      in_a     = {W{1'b1}};
      in_b     = {W{1'b1}};
      in_valid = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checkOutput("stream_in_ready", 64'(in_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
`endif
      waitIdle();

      $display("[TB] identity times 1..16, then all-ones");
      gap_tab = '{0, 0, 0, 0};
      for (int i = 0; i < N; i++)
         for (int k = 0; k < N; k++) begin
            tt.a[(i*N+k)*DW +: DW] = (i == k) ? DW'(1) : DW'(0);
            tt.b[(i*N+k)*DW +: DW] = DW'(4*i + k + 1);
         end
      applyStimulus(tt);
      waitIdle();
      tt.a = {(N*N*DW){1'b1}};
      tt.b = {(N*N*DW){1'b1}};
      applyStimulus(tt);
      waitIdle();

      $display("[TB] reset at edge cycle 5");
      for (int e = 0; e < N*N; e++) begin
         tt.a[e*DW +: DW] = DW'($urandom);
         tt.b[e*DW +: DW] = DW'($urandom);
      end
      applyStimulus(tt);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_a_edge", 64'(a_edge), 64'd0);
      checkOutput("reset_b_edge", 64'(b_edge), 64'd0);
      checkOutput("reset_ctrl", 64'({in_ready, acc_clr, busy, done}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int e = 0; e < N*N; e++) begin
         tt.a[e*DW +: DW] = DW'($urandom);
         tt.b[e*DW +: DW] = DW'($urandom);
      end
      applyStimulus(tt);
      waitIdle();

      $display("[TB] random tiles with random gaps");
      for (int n = 0; n < 6; n++) begin
         for (int e = 0; e < N*N; e++) begin
            tt.a[e*DW +: DW] = DW'($urandom);
            tt.b[e*DW +: DW] = DW'($urandom);
         end
         for (int k = 0; k < N; k++) gap_tab[k] = $urandom_range(0, 2);
         applyStimulus(tt);
         waitIdle();
      end

`ifdef SKEW_FEEDER_PINGPONG_EN
      $display("[TB] back-to-back tiles through both banks");
      gap_tab = '{0, 0, 0, 0};
      for (int n = 0; n < 3; n++) begin
         for (int e = 0; e < N*N; e++) begin
            tt.a[e*DW +: DW] = DW'($urandom);
            tt.b[e*DW +: DW] = DW'($urandom);
         end
         applyStimulus(tt);
      end
      waitIdle();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
